// File: rtl/nes_mem_arbiter.sv
// nes_mem_arbiter
//
// Arbitrates three requesters (0 = PRG fetch, 1 = CHR window fill,
// 2 = PSRAM work RAM) onto one memory-controller port. It keeps at most one
// transaction outstanding. In IDLE the winner's address, write enable and
// write data are registered. The controller gets a one-cycle m_req pulse and
// the winner a one-cycle rq_ack. In WAIT, m_ready loads rq_rdata, pulses
// rq_rdy to the granted requester and returns to IDLE.
//
// Ports
//   clk_sys, rst          clock, asynchronous active-high reset
//   rq_req/rq_wren [2:0]  per-requester request level and write enable
//   rq_addr0..2 [22:0]    per-requester word address
//   rq_wdata0..2 [15:0]   per-requester write data
//   rq_ack/rq_rdy [2:0]   one-hot grant / completion pulses
//   rq_rdata [15:0]       shared read data, valid with rq_rdy
//   m_addr, m_to_mem,     memory-controller command (registered at grant)
//   m_wren, m_req
//   m_ready, m_from_mem   memory-controller completion and read data
//   busy                  high while a transaction is outstanding
//
// Build option
//   NES_MEM_ARB_ROUND_ROBIN_EN  undefined: fixed priority 0 > 1 > 2.
//                               defined: rotating priority. After a grant to
//                               k the order is k+1, k+2, k.
//
// States
//   IDLE | no transaction outstanding, accepting requests
//   WAIT | command issued, waiting for m_ready

module nes_mem_arbiter (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [2:0]  rq_req,
    input  logic [22:0] rq_addr0,
    input  logic [22:0] rq_addr1,
    input  logic [22:0] rq_addr2,
    input  logic [2:0]  rq_wren,
    input  logic [15:0] rq_wdata0,
    input  logic [15:0] rq_wdata1,
    input  logic [15:0] rq_wdata2,
    output logic [2:0]  rq_ack,
    output logic [2:0]  rq_rdy,
    output logic [15:0] rq_rdata,
    output logic [22:0] m_addr,
    output logic [15:0] m_to_mem,
    output logic        m_wren,
    output logic        m_req,
    input  logic        m_ready,
    input  logic [15:0] m_from_mem,
    output logic        busy
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [2:0]  ack_q, ack_d;
    logic [2:0]  rdy_q, rdy_d;
    logic [15:0] rdata_q, rdata_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wren_q, wren_d;
    logic        mreq_q, mreq_d;
    logic [1:0]  first;
    logic [1:0]  win;
    logic [22:0] win_addr;
    logic [15:0] win_wdata;

    // Scan the three requesters starting at 'first', wrapping after 2.
    function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        idx   = start;
        for (int j = 0; j < 3; j++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
    endfunction

`ifdef NES_MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    assign first = ptr_q;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end

    // The pointer names the highest-priority requester and moves only on a grant.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && |rq_req)
            ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end
`else
    assign first = 2'd0;
`endif

    assign win = pick(rq_req, first);

    always_comb begin
        case (win)
            2'd1:    begin win_addr = rq_addr1; win_wdata = rq_wdata1; end
            2'd2:    begin win_addr = rq_addr2; win_wdata = rq_wdata2; end
            default: begin win_addr = rq_addr0; win_wdata = rq_wdata0; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = 3'b000;
        rdy_d   = 3'b000;
        mreq_d  = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = wren_q;
        case (state_q)
            IDLE: begin
                if (|rq_req) begin
                    state_d = WAIT;
                    gnt_d   = win;
                    ack_d   = 3'b001 << win;
                    mreq_d  = 1'b1;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    wren_d  = rq_wren[win];
                end
            end
            WAIT: begin
                // Loaded on writes as well; requesters ignore it then.
                if (m_ready) begin
                    state_d = IDLE;
                    rdata_d = m_from_mem;
                    rdy_d   = 3'b001 << gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'd0;
            ack_q   <= 3'b000;
            rdy_q   <= 3'b000;
            mreq_q  <= 1'b0;
            rdata_q <= 16'h0000;
            addr_q  <= 23'h0;
            wdata_q <= 16'h0000;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdy_q   <= rdy_d;
            mreq_q  <= mreq_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
        end
    end

    assign rq_ack   = ack_q;
    assign rq_rdy   = rdy_q;
    assign rq_rdata = rdata_q;
    assign m_addr   = addr_q;
    assign m_to_mem = wdata_q;
    assign m_wren   = wren_q;
    assign m_req    = mreq_q;
    assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_nes_mem_arbiter.sv
module tb_nes_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [2:0]  rq_req;
    logic [22:0] addr_a [3];
    logic [15:0] wd_a [3];
    logic [2:0]  rq_wren;
    logic [2:0]  rq_ack, rq_rdy;
    logic [15:0] rq_rdata;
    logic [22:0] m_addr;
    logic [15:0] m_to_mem;
    logic        m_wren, m_req, busy;
    logic        m_ready;
    logic [15:0] m_from_mem;

    nes_mem_arbiter dut (
        .clk_sys(clk_sys), .rst(rst),
        .rq_req(rq_req),
        .rq_addr0(addr_a[0]), .rq_addr1(addr_a[1]), .rq_addr2(addr_a[2]),
        .rq_wren(rq_wren),
        .rq_wdata0(wd_a[0]), .rq_wdata1(wd_a[1]), .rq_wdata2(wd_a[2]),
        .rq_ack(rq_ack), .rq_rdy(rq_rdy), .rq_rdata(rq_rdata),
        .m_addr(m_addr), .m_to_mem(m_to_mem), .m_wren(m_wren), .m_req(m_req),
        .m_ready(m_ready), .m_from_mem(m_from_mem), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, winner found by scanning
    // the priority order that starts at ptr_m.
    bit          busy_m  = 0;
    int          gidx_m  = 0;
    int          ptr_m   = 0;
    bit [2:0]    e_ack   = 0;
    bit [2:0]    e_rdy   = 0;
    bit          e_mreq  = 0;
    bit [22:0]   e_addr  = 0;
    bit [15:0]   e_wd    = 0;
    bit          e_wren  = 0;
    bit [15:0]   e_rdata = 0;

    always @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            busy_m = 0; gidx_m = 0; ptr_m = 0;
            e_ack = 0; e_rdy = 0; e_mreq = 0;
            e_addr = 0; e_wd = 0; e_wren = 0; e_rdata = 0;
        end else begin
            e_ack = 0; e_rdy = 0; e_mreq = 0;
            if (!busy_m) begin
                if (rq_req != 3'b000) begin
                    int w;
                    w = -1;
                    for (int j = 0; j < 3; j++)
                        if (w < 0 && rq_req[(ptr_m + j) % 3]) w = (ptr_m + j) % 3;
                    e_ack[w] = 1'b1;
                    e_mreq   = 1'b1;
                    e_addr   = addr_a[w];
                    e_wd     = wd_a[w];
                    e_wren   = rq_wren[w];
                    busy_m   = 1;
                    gidx_m   = w;
`ifdef NES_MEM_ARB_ROUND_ROBIN_EN
                    ptr_m    = (w + 1) % 3;
`endif
                end
            end else if (m_ready) begin
                e_rdata        = m_from_mem;
                e_rdy[gidx_m]  = 1'b1;
                busy_m         = 0;
            end
        end
    end

    // Compare process and event logs, sampled on the falling edge.
    int cyc = 0;
    int grant_q [$];
    int mreq_t [$];
    int rdy_t [$];
    bit busy_log [$];
    logic [22:0] cap_addr = 0;
    logic [15:0] cap_wd = 0;
    logic        cap_wren = 0;
    logic [2:0]  last_rdy = 0;
    logic        prev_mreq = 0;

    always @(negedge clk_sys) begin
        chk("busy", {31'b0, busy}, {31'b0, busy_m});
        chk("rq_ack", {29'b0, rq_ack}, {29'b0, e_ack});
        chk("rq_rdy", {29'b0, rq_rdy}, {29'b0, e_rdy});
        chk("m_req", {31'b0, m_req}, {31'b0, e_mreq});
        chk("m_addr", {9'b0, m_addr}, {9'b0, e_addr});
        chk("m_to_mem", {16'b0, m_to_mem}, {16'b0, e_wd});
        chk("m_wren", {31'b0, m_wren}, {31'b0, e_wren});
        chk("rq_rdata", {16'b0, rq_rdata}, {16'b0, e_rdata});
        chk("m_req_consecutive", {31'b0, m_req & prev_mreq}, 32'd0);
        prev_mreq = m_req;
        busy_log.push_back(busy);
        if (rq_ack != 3'b000) grant_q.push_back(rq_ack == 3'b001 ? 0 : (rq_ack == 3'b010 ? 1 : 2));
        if (m_req) begin
            mreq_t.push_back(cyc);
            cap_addr = m_addr; cap_wd = m_to_mem; cap_wren = m_wren;
        end
        if (rq_rdy != 3'b000) begin
            rdy_t.push_back(cyc);
            last_rdy = rq_rdy;
        end
        cyc++;
    end

    // Stimulus: requesters and a memory controller with fixed latency.
    bit        mem_auto = 1;
    int        mem_lat = 1;
    int        mem_cnt = 0;
    bit [15:0] mem_data = 0;
    bit        drop_on_ack = 1;
    int        g0, m0, r0;

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (drop_on_ack) rq_req = rq_req & ~rq_ack;
        if (mem_auto) begin
            m_ready = 1'b0;
            if (m_req) mem_cnt = mem_lat;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    m_ready    = 1'b1;
                    m_from_mem = mem_data;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rq_req = 3'b000; m_ready = 1'b0; mem_cnt = 0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        g0 = grant_q.size(); m0 = mreq_t.size(); r0 = rdy_t.size();
    endtask

    task automatic wait_rdy(input int n, input int budget);
        int seen = 0;
        int k = 0;
        while (seen < n && k < budget) begin
            tick();
            k++;
            if (rq_rdy != 3'b000) seen++;
        end
        if (seen < n) chk("rdy_timeout", seen, n);
    endtask

    task automatic chk_order(input string name, input int e0, input int e1, input int e2,
                             input int e3, input int n);
        int e [4];
        e = '{e0, e1, e2, e3};
        chk({name, "_count"}, grant_q.size() - g0, n);
        for (int i = 0; i < n; i++)
            if (g0 + i < grant_q.size()) chk({name, "_grant"}, grant_q[g0 + i], e[i]);
    endtask

    initial begin
        rst = 1'b1; rq_req = 3'b000; rq_wren = 3'b000; m_ready = 1'b0; m_from_mem = 16'h0;
        for (int i = 0; i < 3; i++) begin addr_a[i] = 23'h0; wd_a[i] = 16'h0; end

        do_reset();
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_m_addr", {9'b0, m_addr}, 32'd0);
        chk("reset_rq_rdata", {16'b0, rq_rdata}, 32'd0);

        // Single read, m_ready 4 cycles after m_req
        addr_a[0] = 23'h000123; mem_lat = 4; mem_data = 16'hBEEF; drop_on_ack = 1;
        rq_req = 3'b001;
        wait_rdy(1, 20);
        repeat (3) tick();
        chk_order("single", 0, 0, 0, 0, 1);
        chk("single_mreq_count", mreq_t.size() - m0, 1);
        chk("single_rdy_count", rdy_t.size() - r0, 1);
        if (rdy_t.size() > r0 && mreq_t.size() > m0)
            chk("single_latency", rdy_t[r0] - mreq_t[m0], 4);
        chk("single_m_addr", {9'b0, cap_addr}, 32'h000123);
        chk("single_rdy", {29'b0, last_rdy}, 32'b001);
        chk("single_rdata", {16'b0, rq_rdata}, 32'hBEEF);

`ifndef NES_MEM_ARB_ROUND_ROBIN_EN
        // Fixed priority, all three requesting, each drops after its ack
        do_reset();
        addr_a[1] = 23'h000200; addr_a[2] = 23'h000300; mem_lat = 2; mem_data = 16'h1111;
        drop_on_ack = 1; rq_req = 3'b111;
        wait_rdy(3, 60);
        repeat (4) tick();
        chk_order("fixed_111", 0, 1, 2, 0, 3);
        chk("fixed_111_mreq_count", mreq_t.size() - m0, 3);

        // Fixed priority: requester 0 re-requesting starves requester 1
        do_reset();
        drop_on_ack = 0; rq_req = 3'b011;
        wait_rdy(3, 60);
        rq_req = 3'b000;
        repeat (3) tick();
        chk_order("fixed_011", 0, 0, 0, 0, 3);
`else
        do_reset();
        mem_lat = 2; mem_data = 16'h2222; drop_on_ack = 0; rq_req = 3'b011;
        wait_rdy(4, 60);
        rq_req = 3'b000;
        repeat (3) tick();
        chk_order("rr_011", 0, 1, 0, 1, 4);

        do_reset();
        drop_on_ack = 0; rq_req = 3'b111;
        wait_rdy(4, 60);
        rq_req = 3'b000;
        repeat (3) tick();
        chk_order("rr_111", 0, 1, 2, 0, 4);
`endif

        // Write from requester 2
        do_reset();
        drop_on_ack = 1; mem_lat = 3; mem_data = 16'h7777;
        addr_a[2] = 23'h400010; wd_a[2] = 16'h5A5A; rq_wren = 3'b100; rq_req = 3'b100;
        wait_rdy(1, 20);
        repeat (2) tick();
        chk_order("write", 2, 0, 0, 0, 1);
        chk("write_m_wren", {31'b0, cap_wren}, 32'd1);
        chk("write_m_to_mem", {16'b0, cap_wd}, 32'h5A5A);
        chk("write_m_addr", {9'b0, cap_addr}, 32'h400010);
        chk("write_rdy", {29'b0, last_rdy}, 32'b100);
        rq_wren = 3'b000;

        // Reset two cycles into WAIT, then a spurious completion
        do_reset();
        mem_auto = 0; m_ready = 1'b0; drop_on_ack = 1; rq_req = 3'b001;
        begin
            int k = 0;
            while (!m_req && k < 10) begin tick(); k++; end
            if (!m_req) chk("midwait_grant_timeout", 0, 1);
        end
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midwait_busy", {31'b0, busy}, 32'd0);
        chk("midwait_outputs", {rq_ack, rq_rdy, m_req, m_wren}, 32'd0);
        chk("midwait_m_addr", {9'b0, m_addr}, 32'd0);
        chk("midwait_m_to_mem", {16'b0, m_to_mem}, 32'd0);
        chk("midwait_rdata", {16'b0, rq_rdata}, 32'd0);
        r0 = rdy_t.size();
        m_ready = 1'b1; m_from_mem = 16'hDEAD;
        tick();
        m_ready = 1'b0;
        repeat (2) tick();
        chk("spurious_rdy_count", rdy_t.size() - r0, 0);
        chk("spurious_busy", {31'b0, busy}, 32'd0);
        chk("spurious_rdata", {16'b0, rq_rdata}, 32'd0);
        mem_auto = 1;

        // Back-to-back with single-cycle controller latency
        do_reset();
        mem_lat = 1; mem_data = 16'h0042; drop_on_ack = 0; rq_req = 3'b001;
        wait_rdy(3, 30);
        rq_req = 3'b000;
        repeat (3) tick();
        chk("b2b_mreq_count", mreq_t.size() - m0, 3);
        if (mreq_t.size() >= m0 + 3) begin
            chk("b2b_spacing_1", mreq_t[m0 + 1] - mreq_t[m0], 2);
            chk("b2b_spacing_2", mreq_t[m0 + 2] - mreq_t[m0 + 1], 2);
            chk("b2b_busy_gap", {31'b0, busy_log[mreq_t[m0] + 1]}, 32'd0);
            chk("b2b_busy_again", {31'b0, busy_log[mreq_t[m0] + 2]}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nes_mem_arbiter.md
NES_MEM_ARBITER -- requirements
Module: nes_mem_arbiter

Interface
REQ-001 The block SHALL have the following ports, clock and reset first:
- clk_sys  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- rq_req[2:0]  in  3  request level per requester; 0=PRG fetch, 1=CHR window fill, 2=PSRAM work RAM.
- rq_addr0/1/2  in  23 each  word address per requester.
- rq_wren[2:0]  in  3  write enable per requester.
- rq_wdata0/1/2  in  16 each  write data per requester.
- rq_ack[2:0]  out  3  one-cycle grant pulse to the accepted requester.
- rq_rdy[2:0]  out  3  one-cycle completion pulse to the granted requester.
- rq_rdata  out  16  read data, shared by all requesters, valid when rq_rdy is asserted.
- m_addr  out  23  memory-controller address.
- m_to_mem  out  16  memory-controller write data.
- m_wren  out  1  memory-controller write enable.
- m_req  out  1  one-cycle request pulse to the memory controller.
- m_ready  in  1  completion pulse from the memory controller.
- m_from_mem  in  16  read data from the memory controller.
- busy  out  1  high while a transaction is outstanding.
REQ-002 The block SHALL have no parameters; the requester count is fixed at 3.

Function
REQ-003 States SHALL be IDLE and WAIT only; at most one transaction SHALL be outstanding at a time.
REQ-004 In IDLE, when any rq_req bit is high at edge N, the block SHALL select one winner.
REQ-005 At edge N the block SHALL register m_addr, m_wren and m_to_mem from the winner.
REQ-006 At edge N the block SHALL set m_req=1 and rq_ack[winner]=1, both for exactly one cycle, and go to WAIT.
REQ-007 Requesters SHALL hold rq_req and their operands stable until rq_ack; the arbiter SHALL ignore rq_req of losers and keep them pending.
REQ-008 In WAIT, on m_ready=1 the block SHALL register rq_rdata<=m_from_mem, pulse rq_rdy[granted] for one cycle and return to IDLE.
REQ-009 The earliest next grant SHALL be the edge after the m_ready edge; minimum issue-to-issue spacing is therefore m_ready latency plus 1 cycle.
REQ-010 rq_rdata SHALL be loaded for writes too; requesters SHALL ignore it on write completions.
REQ-011 rq_req bits that are high in WAIT SHALL have no effect until IDLE.
REQ-012 m_ready in IDLE SHALL be ignored and SHALL produce no rq_rdy.
REQ-013 busy SHALL equal (state==WAIT).
REQ-014 rq_ack and rq_rdy SHALL be one-hot or zero in every cycle.
REQ-015 m_req SHALL never be asserted in two consecutive cycles.

Reset
REQ-016 On rst=1, asynchronously, the block SHALL force state=IDLE and rq_ack=0, rq_rdy=0, m_req=0, m_wren=0.
REQ-017 On rst=1 the block SHALL force m_addr=0, m_to_mem=0, rq_rdata=0 and the grant index to 0.
REQ-018 On rst=1 the block SHALL set the round-robin pointer, when compiled in, to 0.
REQ-019 Reset asserted in WAIT SHALL abandon the transaction; no rq_rdy SHALL be issued for it, and a later m_ready SHALL be ignored per REQ-012.

Configuration
REQ-020 Arbitration policy SHALL be selected by the macro NES_MEM_ARB_ROUND_ROBIN_EN.
- Undefined: fixed priority, 0 > 1 > 2.
- Defined: rotating priority; after a grant to index k, priority order becomes k+1, k+2, k (mod 3).
- Defined: the pointer SHALL update only on a grant.
- Defined: the reset priority order SHALL be 0 > 1 > 2.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single read: rq_req=001, rq_addr0=0x000123, m_ready 4 cycles after m_req with m_from_mem=0xBEEF -> m_addr=0x000123, rq_ack=001 once, rq_rdy=001 once, rq_rdata=0xBEEF.
- Simultaneous requests, fixed priority (macro undefined): rq_req=111 held -> grant order 0,1,2 and exactly three m_req pulses.
- Simultaneous requests, round-robin (macro defined): rq_req=011 held for four transactions -> grant order 0,1,0,1.
- Round-robin, three requesters: rq_req=111 -> grant order 0,1,2,0.
- Write: rq_req=100, rq_wren=100, rq_wdata2=0x5A5A, rq_addr2=0x400010 -> m_wren=1, m_to_mem=0x5A5A, m_addr=0x400010, rq_rdy=100 on m_ready.
- Reset mid-WAIT, then spurious completion: rst pulsed 2 cycles after m_req, then m_ready=1 -> no rq_rdy, busy=0, all outputs at reset values.
- Back-to-back spacing: rq_req=001 held, m_ready 1 cycle after each m_req -> m_req pulses exactly 2 cycles apart and busy low for one cycle between transactions.
